// File: rtl/memory_port_master_arbiter.sv
// Two-master round-robin arbiter for a single memory port. A tag queue records
// the owner of each outstanding read so responses are routed back in issue order.
module memory_port_master_arbiter #(
  parameter int QUEUE_DEPTH   = 8,
  parameter int QUEUE_DEPTH_N = 3
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iM0_REQ,
  output logic        oM0_LOCK,
  input  logic [1:0]  iM0_ORDER,
  input  logic [3:0]  iM0_MASK,
  input  logic        iM0_RW,
  input  logic [31:0] iM0_ADDR,
  input  logic [31:0] iM0_DATA,
  output logic        oM0_VALID,
  input  logic        iM0_BUSY,
  output logic [63:0] oM0_DATA,
  input  logic        iM1_REQ,
  output logic        oM1_LOCK,
  input  logic [1:0]  iM1_ORDER,
  input  logic [3:0]  iM1_MASK,
  input  logic        iM1_RW,
  input  logic [31:0] iM1_ADDR,
  input  logic [31:0] iM1_DATA,
  output logic        oM1_VALID,
  input  logic        iM1_BUSY,
  output logic [63:0] oM1_DATA,
  output logic        oMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  output logic [1:0]  oMEMORY_ORDER,
  output logic [3:0]  oMEMORY_MASK,
  output logic        oMEMORY_RW,
  output logic [31:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_VALID,
  output logic        oMEMORY_BUSY,
  input  logic [63:0] iMEMORY_DATA,
  output logic        oERR_UNEXPECTED
);

  localparam logic [QUEUE_DEPTH_N:0] FULL_COUNT = (QUEUE_DEPTH_N+1)'(QUEUE_DEPTH);

  logic                     prio;
  logic [QUEUE_DEPTH_N:0]   count;
  logic [QUEUE_DEPTH_N-1:0] rd_ptr;
  logic [QUEUE_DEPTH_N-1:0] wr_ptr;
  logic                     tag_q [QUEUE_DEPTH];

  logic        common_lock;
  logic        grant0_p0;
  logic        grant1_p0;
  logic        grant_p0;
  logic        enq_p0;
  logic        deq_p0;
  logic        nonempty;
  logic        head_tag;
  logic        head_ready;

  logic        mem_req_p1;
  logic [1:0]  mem_order_p1;
  logic [3:0]  mem_mask_p1;
  logic        mem_rw_p1;
  logic [31:0] mem_addr_p1;
  logic [31:0] mem_data_p1;

  logic        rsp0_vld_p1;
  logic [63:0] rsp0_data_p1;
  logic        rsp1_vld_p1;
  logic [63:0] rsp1_data_p1;
  logic        err_unexpected;

  // Stage p0: arbitration and queue bookkeeping on the start-of-cycle count
  assign common_lock = iMEMORY_LOCK || (count == FULL_COUNT);
  assign oM0_LOCK    = common_lock || (iM1_REQ && prio);
  assign oM1_LOCK    = common_lock || (iM0_REQ && !prio);
  assign grant0_p0   = iM0_REQ && !oM0_LOCK;
  assign grant1_p0   = iM1_REQ && !oM1_LOCK;
  assign grant_p0    = grant0_p0 || grant1_p0;
  assign enq_p0      = grant0_p0 ? !iM0_RW : (grant1_p0 && !iM1_RW);

  assign nonempty     = (count != '0);
  assign head_tag     = tag_q[rd_ptr];
  assign head_ready   = head_tag ? (!rsp1_vld_p1 || !iM1_BUSY) : (!rsp0_vld_p1 || !iM0_BUSY);
  assign oMEMORY_BUSY = nonempty && !head_ready;
  assign deq_p0       = iMEMORY_VALID && nonempty && head_ready;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      prio   <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (grant0_p0) prio <= 1'b1;
      else if (grant1_p0) prio <= 1'b0;
      if (enq_p0) wr_ptr <= wr_ptr + 1'b1;
      if (deq_p0) rd_ptr <= rd_ptr + 1'b1;
      unique case ({enq_p0, deq_p0})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (enq_p0) tag_q[wr_ptr] <= grant1_p0;
  end

  // Stage p1: registered request toward memory, held while memory stalls
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      mem_req_p1   <= 1'b0;
      mem_order_p1 <= '0;
      mem_mask_p1  <= '0;
      mem_rw_p1    <= 1'b0;
      mem_addr_p1  <= '0;
      mem_data_p1  <= '0;
    end else if (grant_p0) begin
      mem_req_p1   <= 1'b1;
      mem_order_p1 <= grant1_p0 ? iM1_ORDER : iM0_ORDER;
      mem_mask_p1  <= grant1_p0 ? iM1_MASK  : iM0_MASK;
      mem_rw_p1    <= grant1_p0 ? iM1_RW    : iM0_RW;
      mem_addr_p1  <= grant1_p0 ? iM1_ADDR  : iM0_ADDR;
      mem_data_p1  <= grant1_p0 ? iM1_DATA  : iM0_DATA;
    end else if (!iMEMORY_LOCK) begin
      mem_req_p1   <= 1'b0;
    end
  end

  // Stage p1: per-master response registers; a consumed entry clears unless reloaded
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      rsp0_vld_p1    <= 1'b0;
      rsp0_data_p1   <= '0;
      rsp1_vld_p1    <= 1'b0;
      rsp1_data_p1   <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (deq_p0 && !head_tag) begin
        rsp0_vld_p1  <= 1'b1;
        rsp0_data_p1 <= iMEMORY_DATA;
      end else if (!iM0_BUSY) begin
        rsp0_vld_p1  <= 1'b0;
      end
      if (deq_p0 && head_tag) begin
        rsp1_vld_p1  <= 1'b1;
        rsp1_data_p1 <= iMEMORY_DATA;
      end else if (!iM1_BUSY) begin
        rsp1_vld_p1  <= 1'b0;
      end
      if (iMEMORY_VALID && !nonempty) err_unexpected <= 1'b1;
    end
  end

  assign oMEMORY_REQ     = mem_req_p1;
  assign oMEMORY_ORDER   = mem_order_p1;
  assign oMEMORY_MASK    = mem_mask_p1;
  assign oMEMORY_RW      = mem_rw_p1;
  assign oMEMORY_ADDR    = mem_addr_p1;
  assign oMEMORY_DATA    = mem_data_p1;
  assign oM0_VALID       = rsp0_vld_p1;
  assign oM0_DATA        = rsp0_data_p1;
  assign oM1_VALID       = rsp1_vld_p1;
  assign oM1_DATA        = rsp1_data_p1;
  assign oERR_UNEXPECTED = err_unexpected;

endmodule

// File: tb/tb_memory_port_master_arbiter.sv
// Scoreboard bench for memory_port_master_arbiter: random masters and memory,
// checked against a transaction-level model of arbitration, ordering and routing.
module tb_memory_port_master_arbiter;

  localparam int QD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_lock, m0_rw, m0_valid, m0_busy;
  logic [1:0]  m0_order;
  logic [3:0]  m0_mask;
  logic [31:0] m0_addr, m0_wdata;
  logic [63:0] m0_rdata;
  logic        m1_req, m1_lock, m1_rw, m1_valid, m1_busy;
  logic [1:0]  m1_order;
  logic [3:0]  m1_mask;
  logic [31:0] m1_addr, m1_wdata;
  logic [63:0] m1_rdata;
  logic        mem_req, mem_lock, mem_rw, mem_valid, mem_busy, err;
  logic [1:0]  mem_order;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata;

  memory_port_master_arbiter #(.QUEUE_DEPTH(QD), .QUEUE_DEPTH_N(3)) dut (
    .iCLOCK(clk), .iRESET_SYNC(rst),
    .iM0_REQ(m0_req), .oM0_LOCK(m0_lock), .iM0_ORDER(m0_order), .iM0_MASK(m0_mask),
    .iM0_RW(m0_rw), .iM0_ADDR(m0_addr), .iM0_DATA(m0_wdata), .oM0_VALID(m0_valid),
    .iM0_BUSY(m0_busy), .oM0_DATA(m0_rdata),
    .iM1_REQ(m1_req), .oM1_LOCK(m1_lock), .iM1_ORDER(m1_order), .iM1_MASK(m1_mask),
    .iM1_RW(m1_rw), .iM1_ADDR(m1_addr), .iM1_DATA(m1_wdata), .oM1_VALID(m1_valid),
    .iM1_BUSY(m1_busy), .oM1_DATA(m1_rdata),
    .oMEMORY_REQ(mem_req), .iMEMORY_LOCK(mem_lock), .oMEMORY_ORDER(mem_order),
    .oMEMORY_MASK(mem_mask), .oMEMORY_RW(mem_rw), .oMEMORY_ADDR(mem_addr),
    .oMEMORY_DATA(mem_wdata), .iMEMORY_VALID(mem_valid), .oMEMORY_BUSY(mem_busy),
    .iMEMORY_DATA(mem_rdata), .oERR_UNEXPECTED(err)
  );

  typedef struct packed {
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  // Reference model state
  req_t        exp_req[$];
  bit          outst[$];
  logic [63:0] pending[$];
  logic [63:0] exp_rsp0[$];
  logic [63:0] exp_rsp1[$];
  bit          pref;
  bit          err_m;
  bit          armed;

  int n_checks = 0;
  int n_err    = 0;

  int p_req0, p_req1, p_rw, p_busy, p_mlock, p_mvalid;
  bit stray;

  function automatic bit roll(int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive();
    m0_req   = roll(p_req0);
    m0_rw    = roll(p_rw);
    m0_order = 2'($urandom);
    m0_mask  = 4'($urandom);
    m0_addr  = $urandom;
    m0_wdata = $urandom;
    m0_busy  = roll(p_busy);
    m1_req   = roll(p_req1);
    m1_rw    = roll(p_rw);
    m1_order = 2'($urandom);
    m1_mask  = 4'($urandom);
    m1_addr  = $urandom;
    m1_wdata = $urandom;
    m1_busy  = roll(p_busy);
    mem_lock = roll(p_mlock);
    mem_valid = stray || (pending.size() != 0 && roll(p_mvalid));
    mem_rdata = (pending.size() != 0) ? pending[0] : {$urandom, $urandom};
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  bit   cl, el0, el1, ebusy, v0, v1, acc;
  req_t r;

  always @(negedge clk) begin
    v0    = exp_rsp0.size() != 0;
    v1    = exp_rsp1.size() != 0;
    cl    = mem_lock || (outst.size() == QD);
    el0   = cl || (m1_req && pref);
    el1   = cl || (m0_req && !pref);
    ebusy = outst.size() != 0 && (outst[0] ? (v1 && m1_busy) : (v0 && m0_busy));
    if (armed) begin
      check("m0_lock", m0_lock, el0);
      check("m1_lock", m1_lock, el1);
      check("mem_busy", mem_busy, ebusy);
      check("m0_valid", m0_valid, v0);
      check("m1_valid", m1_valid, v1);
      check("err_unexpected", err, err_m);
      check("mem_req", mem_req, exp_req.size() != 0);
      if (exp_req.size() != 0 && mem_req) begin
        r = exp_req[0];
        check("mem_addr", mem_addr, r.addr);
        check("mem_wdata", mem_wdata, r.data);
        check("mem_rw", mem_rw, r.rw);
        check("mem_order", mem_order, r.order);
        check("mem_mask", mem_mask, r.mask);
      end
      if (v0 && !m0_busy) check("m0_rdata", m0_rdata, exp_rsp0[0]);
      if (v1 && !m1_busy) check("m1_rdata", m1_rdata, exp_rsp1[0]);
    end
    if (rst) begin
      exp_req.delete(); outst.delete(); pending.delete();
      exp_rsp0.delete(); exp_rsp1.delete();
      pref  = 1'b0;
      err_m = 1'b0;
      armed = 1'b1;
    end else begin
      acc = mem_valid && outst.size() != 0 && !ebusy;
      if (v0 && !m0_busy) void'(exp_rsp0.pop_front());
      if (v1 && !m1_busy) void'(exp_rsp1.pop_front());
      if (mem_valid && outst.size() == 0) err_m = 1'b1;
      if (acc && pending.size() != 0) begin
        if (outst.pop_front()) exp_rsp1.push_back(pending.pop_front());
        else exp_rsp0.push_back(pending.pop_front());
      end
      if (exp_req.size() != 0 && !mem_lock) begin
        r = exp_req.pop_front();
        if (!r.rw) pending.push_back({$urandom, $urandom});
      end
      if (m0_req && !el0) begin
        exp_req.push_back('{m0_order, m0_mask, m0_rw, m0_addr, m0_wdata});
        if (!m0_rw) outst.push_back(1'b0);
        pref = 1'b1;
      end else if (m1_req && !el1) begin
        exp_req.push_back('{m1_order, m1_mask, m1_rw, m1_addr, m1_wdata});
        if (!m1_rw) outst.push_back(1'b1);
        pref = 1'b0;
      end
    end
  end

  initial begin
    armed = 1'b0; pref = 1'b0; err_m = 1'b0; stray = 1'b0;
    p_req0 = 0; p_req1 = 0; p_rw = 0; p_busy = 0; p_mlock = 0; p_mvalid = 0;
    rst = 1'b1;
    drive();
    run(3);
    rst = 1'b0;
    // single M0 read, then its response
    p_req0 = 100; run(1);
    p_req0 = 0; p_mvalid = 100; run(6);
    // both masters reading every cycle: alternating grants
    p_req0 = 100; p_req1 = 100; run(16);
    p_req0 = 0; p_req1 = 0; run(10);
    // posted M1 write
    p_req1 = 100; p_rw = 100; run(2);
    p_req1 = 0; run(4);
    // fill the tag queue with no responses, then try writes
    p_req0 = 100; p_rw = 0; p_mvalid = 0; run(12);
    p_rw = 100; run(3);
    p_req0 = 0; p_mvalid = 100; run(14);
    // head-of-line M1 with busy masters
    p_req1 = 100; p_rw = 0; p_mvalid = 0; run(3);
    p_req1 = 0; p_busy = 100; p_mvalid = 100; run(6);
    p_busy = 0; run(8);
    // memory stall while requests are pending
    p_req0 = 100; p_req1 = 100; p_mlock = 100; run(5);
    p_mlock = 0; run(3);
    p_req0 = 0; p_req1 = 0; run(12);
    // randomized traffic
    p_req0 = 50; p_req1 = 50; p_rw = 40; p_busy = 30; p_mlock = 20; p_mvalid = 60;
    run(3000);
    run(15);
    // reset mid-traffic, then a stray response
    p_req0 = 0; p_req1 = 0; p_mvalid = 0; p_busy = 0; p_mlock = 0;
    rst = 1'b1; run(2);
    rst = 1'b0; run(2);
    stray = 1'b1; run(1);
    stray = 1'b0; run(4);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/memory_port_master_arbiter.md
Name: memory_port_master_arbiter

Overview:
- Shares the single external memory port between two masters: M0 (core-side memory pipe) and M1 (DMA/IO engine).
- Round-robin request grant with a registered request stage toward memory.
- An in-order tag queue records the owning master of each outstanding read and routes each read response back to that master. Writes are posted and produce no response.

Parameters:
QUEUE_DEPTH, 8, max outstanding reads (power of two)
QUEUE_DEPTH_N, 3, log2(QUEUE_DEPTH)

Ports:
iCLOCK  in  1  clock
iRESET_SYNC  in  1  synchronous active-high reset
iM0_REQ  in  1  M0 request
oM0_LOCK  out  1  M0 stall; transfer = iM0_REQ && !oM0_LOCK
iM0_ORDER  in  2  access size
iM0_MASK  in  4  byte mask
iM0_RW  in  1  1=write 0=read
iM0_ADDR  in  32  address
iM0_DATA  in  32  write data
oM0_VALID  out  1  read response valid
iM0_BUSY  in  1  M0 cannot accept response
oM0_DATA  out  64  read response data
iM1_REQ, oM1_LOCK, iM1_ORDER, iM1_MASK, iM1_RW, iM1_ADDR, iM1_DATA, oM1_VALID, iM1_BUSY, oM1_DATA: same as M0, for M1
oMEMORY_REQ  out  1  memory request
iMEMORY_LOCK  in  1  memory stall
oMEMORY_ORDER  out  2  request size
oMEMORY_MASK  out  4  request mask
oMEMORY_RW  out  1  request direction
oMEMORY_ADDR  out  32  request address
oMEMORY_DATA  out  32  request write data
iMEMORY_VALID  in  1  read data valid
oMEMORY_BUSY  out  1  response back-pressure
iMEMORY_DATA  in  64  read data
oERR_UNEXPECTED  out  1  sticky: response arrived with empty queue

Behaviour:
- Clock and reset: single clock iCLOCK; iRESET_SYNC is synchronous, active-high.
- Reset values: all o* registers 0, priority pointer = M0, queue empty (count 0, rd/wr pointers 0), oERR_UNEXPECTED = 0.
- Mid-operation reset flushes the queue and the response registers. Memory must be quiesced before reset; any late response then sets oERR_UNEXPECTED.
- Common lock: common_lock = iMEMORY_LOCK || (count == QUEUE_DEPTH). A full queue blocks writes too.
- Lock outputs (combinational):
  - oM0_LOCK = common_lock || (iM1_REQ && prio == M1).
  - oM1_LOCK = common_lock || (iM0_REQ && prio == M0).
- Grant: at most one transfer per cycle.
  - After any grant, prio points to the non-granted master.
  - A lone requester is granted whatever prio says.
- Request register:
  - On a grant, load the granted master's fields next cycle and set oMEMORY_REQ = 1.
  - With no grant and !iMEMORY_LOCK, oMEMORY_REQ = 0.
  - While iMEMORY_LOCK = 1, all request-register contents hold.
  - Memory accepts on oMEMORY_REQ && !iMEMORY_LOCK.
  - Latency from master transfer to oMEMORY_REQ: 1 cycle.
- Tag queue:
  - A read grant enqueues a 1-bit tag (0 = M0, 1 = M1) in the same cycle.
  - A response accept dequeues. count is updated by +1, -1 or 0.
  - Enqueue and dequeue in the same cycle are legal, including at full: a dequeue at full does not enable an enqueue that cycle, because the lock uses the start-of-cycle count.
  - Pointers wrap modulo QUEUE_DEPTH.
- Response registers (one per master, with valid bit):
  - A master's register can accept when !oMx_VALID || !iMx_BUSY.
  - oMEMORY_BUSY = queue_nonempty && !(head tag's master can accept).
  - Accept = iMEMORY_VALID && queue_nonempty && !oMEMORY_BUSY. On accept, load the head master's register: oMx_VALID = 1, oMx_DATA = iMEMORY_DATA.
  - oMx_VALID holds with stable data until a cycle where iMx_BUSY = 0 consumes it. The register clears unless reloaded that cycle.
  - Response latency: 1 cycle after accept.
- Error case: iMEMORY_VALID with an empty queue drops the data and sets oERR_UNEXPECTED, which stays set until reset.
- Ordering: responses are delivered in issue order; no reordering between masters. A busy head-of-line master stalls responses for the other master (intentional).

Test Plan:
- M0 read only, addr 0x100 → oMEMORY_REQ = 1 with ADDR 0x100 one cycle later. Memory returns 0xDEAD_BEEF → oM0_VALID = 1 next cycle, oM1_VALID stays 0.
- M0 and M1 both request reads every cycle from reset → grants alternate M0, M1, M0, M1. Queue tags 0,1,0,1; responses route in the same order.
- M1 write (RW = 1) → memory sees the write, no queue entry, no oM1_VALID ever.
- Issue 8 M0 reads with no responses → count = 8, both LOCKs = 1, a 9th write is blocked. One response accepted → locks drop next cycle.
- Head tag M1, iM1_BUSY = 1 with oM1_VALID set, iMEMORY_VALID = 1 → oMEMORY_BUSY = 1 and nothing dequeued. Release busy → delivered, count decrements.
- iMEMORY_LOCK = 1 while oMEMORY_REQ = 1 → request fields stable and no new grants. iRESET_SYNC mid-traffic → all outputs 0; a later stray iMEMORY_VALID sets oERR_UNEXPECTED.
